mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the backing memory.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        busy;
  logic        err_timeout;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, busy, err_timeout
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy, err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction and data requesters,
// one transaction outstanding, with a read-response timeout.
//
// state   | meaning
// IDLE    | no transaction; sample requests and pick a winner
// ISSUE   | drive mem_req with latched fields until mem_ready
// WAIT_RD | read accepted; wait for mem_rvalid or timeout
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               rstb,
  mem_port_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          owner_d;
  logic          last_d;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt;
  logic          i_gnt_q;
  logic          d_gnt_q;
  logic          i_rvalid_q;
  logic          d_rvalid_q;
  logic [31:0]   i_rdata_q;
  logic [31:0]   d_rdata_q;
  logic          err_q;

  logic any_req;
  logic pick_d;
  logic in_issue;

  assign any_req  = bus.i_req | bus.d_req;
  // data wins when alone, or on a tie when instruction was granted last
  assign pick_d   = bus.d_req & (~bus.i_req | ~last_d);
  assign in_issue = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      last_d     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= ISSUE;
            owner_d <= pick_d;
            last_d  <= pick_d;
            we_q    <= pick_d & bus.d_we;
            addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
            wdata_q <= pick_d ? bus.d_wdata : 32'h0;
            d_gnt_q <= pick_d;
            i_gnt_q <= ~pick_d;
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            cnt <= '0;
            if (we_q) begin
              state      <= IDLE;
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= 32'h0;
            end else begin
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          // real data takes priority over a timeout in the same cycle
          if (bus.mem_rvalid || (cnt == TERM)) begin
            state <= IDLE;
            err_q <= ~bus.mem_rvalid;
            if (owner_d) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= bus.mem_rvalid ? bus.mem_rdata : ERR_DATA;
            end else begin
              i_rvalid_q <= 1'b1;
              i_rdata_q  <= bus.mem_rvalid ? bus.mem_rdata : ERR_DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i_gnt       = i_gnt_q;
  assign bus.d_gnt       = d_gnt_q;
  assign bus.i_rvalid    = i_rvalid_q;
  assign bus.d_rvalid    = d_rvalid_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.mem_req     = in_issue;
  assign bus.mem_we      = in_issue & we_q;
  assign bus.mem_addr    = in_issue ? addr_q : 32'h0;
  assign bus.mem_wdata   = in_issue ? wdata_q : 32'h0;
  assign bus.busy        = (state != IDLE);
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-by-cycle directed vectors for mem_port_arbiter: a main table for arbitration,
// reads and writes, plus hand sequences for delayed ready, timeout and reset.
module tb_mem_port_arbiter;
  localparam logic [31:0] Z    = 32'h0;
  localparam logic [31:0] IA   = 32'h0000_1000;
  localparam logic [31:0] DA   = 32'h1000_0004;
  localparam logic [31:0] DW   = 32'h0000_00AB;
  localparam logic [31:0] ED   = 32'hDEADBEEF;
  localparam logic [31:0] R1   = 32'h1111_2222;
  localparam logic [31:0] R2   = 32'h3333_4444;
  localparam logic [31:0] R3   = 32'h5555_6666;
  localparam logic [31:0] R4   = 32'h7777_8888;
  localparam logic [31:0] R5   = 32'h2002_000A;
  localparam logic [31:0] R6   = 32'h0BAD_F00D;
  localparam logic [31:0] R7   = 32'hCAFE_0001;
  localparam logic [31:0] JUNK = 32'h9999_9999;

  // in_b: {rstb, i_req, d_req, d_we, mem_ready, mem_rvalid}
  // ex_b: {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, mem_we, busy, err_timeout}
  typedef struct {
    logic [5:0]  in_b;
    logic [31:0] m_rdata;
    logic [7:0]  ex_b;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [31:0] e_irdata;
    logic [31:0] e_drdata;
  } vec_t;

  logic clk;
  logic rstb;
  int   total;
  int   bad;
  vec_t tbl [26];

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT  (16),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int idx, input string sig,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] %s: got %h expected %h", tag, idx, sig, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input int idx, input vec_t v);
    logic [7:0] flags;
    @(negedge clk);
    {rstb, bus.i_req, bus.d_req, bus.d_we, bus.mem_ready, bus.mem_rvalid} = v.in_b;
    bus.mem_rdata = v.m_rdata;
    #1;
    flags = {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid,
             bus.mem_req, bus.mem_we, bus.busy, bus.err_timeout};
    check(tag, idx, "flags", 32'(flags), 32'(v.ex_b));
    check(tag, idx, "mem_addr", bus.mem_addr, v.e_maddr);
    check(tag, idx, "mem_wdata", bus.mem_wdata, v.e_mwdata);
    check(tag, idx, "i_rdata", bus.i_rdata, v.e_irdata);
    check(tag, idx, "d_rdata", bus.d_rdata, v.e_drdata);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstb  = 1'b0;
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.i_addr = IA; bus.d_addr = DA; bus.d_wdata = DW;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = Z;

    // tie -> i, tie -> d, write with ready high, reads, stray responses, back-to-back writes
    tbl[0]  = '{6'b000000, Z,    8'b00000000, Z,  Z,  Z,  Z};
    tbl[1]  = '{6'b111110, Z,    8'b00000000, Z,  Z,  Z,  Z};
    tbl[2]  = '{6'b111110, Z,    8'b10001010, IA, Z,  Z,  Z};
    tbl[3]  = '{6'b101101, R1,   8'b00000010, Z,  Z,  Z,  Z};
    tbl[4]  = '{6'b111110, Z,    8'b00100000, Z,  Z,  R1, Z};
    tbl[5]  = '{6'b111110, Z,    8'b01001110, DA, DW, R1, Z};
    tbl[6]  = '{6'b110000, Z,    8'b00010000, Z,  Z,  R1, Z};
    tbl[7]  = '{6'b111010, Z,    8'b10001010, IA, Z,  R1, Z};
    tbl[8]  = '{6'b101001, R2,   8'b00000010, Z,  Z,  R1, Z};
    tbl[9]  = '{6'b111010, Z,    8'b00100000, Z,  Z,  R2, Z};
    tbl[10] = '{6'b111010, Z,    8'b01001010, DA, DW, R2, Z};
    tbl[11] = '{6'b110001, R3,   8'b00000010, Z,  Z,  R2, Z};
    tbl[12] = '{6'b110000, Z,    8'b00010000, Z,  Z,  R2, R3};
    tbl[13] = '{6'b110001, JUNK, 8'b10001010, IA, Z,  R2, R3};
    tbl[14] = '{6'b100001, JUNK, 8'b00001010, IA, Z,  R2, R3};
    tbl[15] = '{6'b100010, Z,    8'b00001010, IA, Z,  R2, R3};
    tbl[16] = '{6'b100001, R4,   8'b00000010, Z,  Z,  R2, R3};
    tbl[17] = '{6'b100000, Z,    8'b00100000, Z,  Z,  R4, R3};
    tbl[18] = '{6'b100001, JUNK, 8'b00000000, Z,  Z,  R4, R3};
    tbl[19] = '{6'b100010, Z,    8'b00000000, Z,  Z,  R4, R3};
    tbl[20] = '{6'b101110, Z,    8'b00000000, Z,  Z,  R4, R3};
    tbl[21] = '{6'b101110, Z,    8'b01001110, DA, DW, R4, R3};
    tbl[22] = '{6'b101110, Z,    8'b00010000, Z,  Z,  R4, Z};
    tbl[23] = '{6'b100110, Z,    8'b01001110, DA, DW, R4, Z};
    tbl[24] = '{6'b100010, Z,    8'b00010000, Z,  Z,  R4, Z};
    tbl[25] = '{6'b100000, Z,    8'b00000000, Z,  Z,  R4, Z};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 26; i++) run_vec("main", i, tbl[i]);

    // instruction read: ready held off three cycles, data two cycles after accept
    run_vec("slow", 0, '{6'b110000, Z,  8'b00000000, Z,  Z, R4, Z});
    run_vec("slow", 1, '{6'b110000, Z,  8'b10001010, IA, Z, R4, Z});
    run_vec("slow", 2, '{6'b100000, Z,  8'b00001010, IA, Z, R4, Z});
    run_vec("slow", 3, '{6'b100000, Z,  8'b00001010, IA, Z, R4, Z});
    run_vec("slow", 4, '{6'b100010, Z,  8'b00001010, IA, Z, R4, Z});
    run_vec("slow", 5, '{6'b100000, Z,  8'b00000010, Z,  Z, R4, Z});
    run_vec("slow", 6, '{6'b100001, R5, 8'b00000010, Z,  Z, R4, Z});
    run_vec("slow", 7, '{6'b100000, Z,  8'b00100000, Z,  Z, R5, Z});

    // data read never answered: 16 waiting cycles, then error response
    run_vec("tmo", 0, '{6'b101010, Z, 8'b00000000, Z,  Z,  R5, Z});
    run_vec("tmo", 1, '{6'b101010, Z, 8'b01001010, DA, DW, R5, Z});
    for (int k = 0; k < 16; k++)
      run_vec("tmo_wait", k, '{6'b100000, Z, 8'b00000010, Z, Z, R5, Z});
    run_vec("tmo", 2, '{6'b100000, Z, 8'b00010001, Z, Z, R5, ED});
    run_vec("tmo", 3, '{6'b100000, Z, 8'b00000000, Z, Z, R5, ED});

    // data arrives exactly in the terminal waiting cycle
    run_vec("edge", 0, '{6'b101010, Z, 8'b00000000, Z,  Z,  R5, ED});
    run_vec("edge", 1, '{6'b101010, Z, 8'b01001010, DA, DW, R5, ED});
    for (int k = 0; k < 15; k++)
      run_vec("edge_wait", k, '{6'b100000, Z, 8'b00000010, Z, Z, R5, ED});
    run_vec("edge", 2, '{6'b100001, R6, 8'b00000010, Z, Z, R5, ED});
    run_vec("edge", 3, '{6'b100000, Z,  8'b00010000, Z, Z, R5, R6});

    // reset while waiting for read data, stray response afterwards, then a tie
    run_vec("rst", 0, '{6'b110010, Z,  8'b00000000, Z,  Z, R5, R6});
    run_vec("rst", 1, '{6'b110010, Z,  8'b10001010, IA, Z, R5, R6});
    run_vec("rst", 2, '{6'b000000, Z,  8'b00000010, Z,  Z, R5, R6});
    run_vec("rst", 3, '{6'b100001, R7, 8'b00000000, Z,  Z, Z,  Z});
    run_vec("rst", 4, '{6'b111001, R7, 8'b00000000, Z,  Z, Z,  Z});
    run_vec("rst", 5, '{6'b111000, Z,  8'b10001010, IA, Z, Z,  Z});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
